count_match_capture: RTL

//  - Sits directly downstream of the 4-bit free-running binary counter and consumes its count output.
//  - Detects counter wrap (max->0) and programmable match events.
//  - Keeps a wrap epoch tag.
//  - Captures {tag,count} snapshots into a small FIFO drained by a valid/ready consumer.

---
 rtl/count_match_capture.sv | 102 ++++++++++
 1 files changed

// File: rtl/count_match_capture.sv
// Watches an upstream free-running counter: flags wraps and match events, keeps a wrap epoch tag,
// and queues {tag,count} snapshots for a valid/ready consumer. OVERFLOW_STICKY_EN makes overflow sticky.
module count_match_capture #(
    parameter int CNT_W = 4,
    parameter int TAG_W = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CNT_W-1:0]         count,
    input  logic                     enable,
    input  logic [CNT_W-1:0]         match_val,
    output logic                     match_pulse,
    output logic                     wrap_pulse,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TAG_W+CNT_W-1:0]   out_data,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = TAG_W + CNT_W;

    typedef enum logic {IDLE, TRACK} state_t;

    state_t                    state;
    logic [CNT_W-1:0]          prev_count;
    logic [TAG_W-1:0]          tag;
    logic [DEPTH-1:0][DW-1:0]  mem;
    logic [AW-1:0]             wr_ptr, rd_ptr;
    logic [LW-1:0]             level;

    logic             tracking, wrap, match, pop, full, push_ok, drop;
    logic [TAG_W-1:0] tag_next;

    assign tracking = (state == TRACK) && enable;
    assign wrap     = tracking && (prev_count == {CNT_W{1'b1}}) && (count == '0);
    // A count held across cycles must not re-fire, hence the change check.
    assign match    = tracking && (count == match_val) && (count != prev_count);
    assign tag_next = tag + TAG_W'(wrap);

    assign out_valid  = (level != '0);
    assign out_data   = mem[rd_ptr];
    assign fifo_level = level;

    assign full    = (level == LW'(DEPTH));
    assign pop     = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push_ok = match && (!full || pop);
    assign drop    = match && full && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            prev_count  <= '0;
            tag         <= '0;
            match_pulse <= 1'b0;
            wrap_pulse  <= 1'b0;
            overflow    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state      <= TRACK;
                        prev_count <= count;
                    end
                end
                TRACK: begin
                    prev_count <= count;
                    if (!enable) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            match_pulse <= match;
            wrap_pulse  <= wrap;
            tag         <= tag_next;

            if (push_ok) begin
                mem[wr_ptr] <= {tag_next, count};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);

            case ({push_ok, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase

`ifdef OVERFLOW_STICKY_EN
            if (drop) overflow <= 1'b1;
`else
            overflow <= drop;
`endif
        end
    end
endmodule
